hazard_ctrl: RTL

Pipeline stall/flush controller for the five-stage RISC-V integer pipeline. It generates the per-stage `Stall*` and `Flush*` signals that drive the enable (as `~Stall`) and clear inputs of the F/D, D/E, E/M and M/W enable-reset-clear pipeline registers. It covers load-use hazards, taken branches, traps, memory stalls and a fixed-latency multicycle divider, which is tracked with an internal state machine and counter.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_ctrl_div_counter.sv | 29 ++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the divider FSM state type and the perf counter width.
package hazard_pkg;

  typedef enum logic {
    RUN = 1'b0,
    DIV = 1'b1
  } hzstate_t;

  localparam int PERFW = 32;

endpackage

// File: rtl/hazard_ctrl_div_counter.sv
// Loadable down-counter with clear, load, decrement and zero flag.
// Used to time the fixed-latency divider stall window.
module div_counter #(
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            load,
  input  logic            dec,
  input  logic [CNTW-1:0] din,
  output logic            zero
);

  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= din;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNTW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (load-use, branch,
// trap, memory stall, divider). Perf counters: HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DIVLEN = 32,
  parameter int CNTW   = $clog2(DIVLEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LoadE,
  input  logic [4:0]       RdE,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             BranchTakenE,
  input  logic             DivStartE,
  input  logic             TrapM,
  input  logic             MemStallM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             DivDoneE,
  output logic [PERFW-1:0] StallCycles,
  output logic [PERFW-1:0] FlushEvents
);

  hzstate_t state, state_n;
  logic     held, held_n;
  logic     zero, ld, dec, clr;
  logic     load_use, start, div_stall;
  logic     br_eff, lu_eff;

  assign load_use = LoadE && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign start     = (state == RUN) && DivStartE && !held;
  assign div_stall = start || ((state == DIV) && !zero);
  assign br_eff    = BranchTakenE && !div_stall;
  assign lu_eff    = load_use && !BranchTakenE;

  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    FlushW   = 1'b0;
    DivDoneE = 1'b0;
    if (!reset) begin
      if (TrapM) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF   = MemStallM || div_stall || lu_eff;
        StallD   = MemStallM || div_stall || lu_eff;
        StallE   = MemStallM || div_stall;
        StallM   = MemStallM;
        // a clear is only effective when its register is enabled
        FlushD   = br_eff && !StallD;
        FlushE   = (br_eff || lu_eff) && !StallE;
        FlushM   = div_stall && !StallM;
        FlushW   = MemStallM;
        DivDoneE = (state == DIV) && zero;
      end
    end
  end

  always_comb begin
    state_n = state;
    held_n  = held;
    ld      = 1'b0;
    dec     = 1'b0;
    clr     = 1'b0;
    if (TrapM) begin
      state_n = RUN;
      held_n  = 1'b0;
      clr     = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (start) begin
            ld      = 1'b1;
            state_n = DIV;
          end
        end
        DIV: begin
          if (zero) state_n = RUN;
          else      dec     = 1'b1;
        end
      endcase
      if (!StallE) held_n = 1'b0;
      // finished divide still parked in Execute: don't restart it
      if (DivDoneE && StallE) held_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      held  <= 1'b0;
    end else begin
      state <= state_n;
      held  <= held_n;
    end
  end

  div_counter #(
    .CNTW(CNTW)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .load (ld),
    .dec  (dec),
    .din  (CNTW'(DIVLEN - 1)),
    .zero (zero)
  );

`ifdef HAZARD_PERF_EN
  logic [PERFW-1:0] sc, fc;

  always_ff @(posedge clk) begin
    if (reset) begin
      sc <= '0;
      fc <= '0;
    end else begin
      sc <= sc + PERFW'(StallF);
      fc <= fc + PERFW'(FlushD);
    end
  end

  assign StallCycles = sc;
  assign FlushEvents = fc;
`else
  assign StallCycles = '0;
  assign FlushEvents = '0;
`endif

endmodule
